// File: rtl/branch_resolve.sv
// branch_resolve: registered branch-resolution stage.
// Resolves the actual direction and next PC of a branch from the comparator
// result. Raises a one-cycle redirect when the fetch-time prediction was wrong.
// Also owns the 2-bit saturating branch history table that fetch reads and
// this stage trains.
module branch_resolve #(
    parameter int BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [31:0] in_cmp_result,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_imm,
    input  logic        in_pred_taken,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_taken,
    output logic [31:0] out_next_pc,
    output logic        out_mispredict,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic [31:0] pred_pc,
    output logic        pred_taken
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [3:0] OP_BLT  = 4'b0100;
    localparam logic [3:0] OP_BGT  = 4'b0101;
    localparam logic [3:0] OP_BLTU = 4'b0110;
    localparam logic [3:0] OP_BGTU = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;

    // Weakly not-taken: the counter value every entry starts from.
    localparam logic [1:0] CNT_INIT = 2'b01;

    logic        out_valid_q,      out_valid_d;
    logic        out_taken_q,      out_taken_d;
    logic [31:0] out_next_pc_q,    out_next_pc_d;
    logic        out_mispredict_q, out_mispredict_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [1:0]  bht_q [BHT_ENTRIES];
    logic [1:0]  bht_d [BHT_ENTRIES];

    logic             is_branch;
    logic             taken;
    logic             mispredict;
    logic [31:0]      next_pc;
    logic             capture;
    logic [IDX_W-1:0] train_idx;
    logic [IDX_W-1:0] query_idx;
    logic [1:0]       train_cnt;

    // Only bit 0 of the comparator result and the index bits of the query PC
    // carry information; the rest are folded here on purpose.
    logic unused_bits;
    assign unused_bits = ^{in_cmp_result[31:1], pred_pc[31:IDX_W+2], pred_pc[1:0]};

    assign train_idx = in_pc[IDX_W+1:2];
    assign query_idx = pred_pc[IDX_W+1:2];

    // Flush wins over the ready path, so it also blocks capture and training.
    assign in_ready = ~flush & (~out_valid_q | out_ready);
    assign capture  = in_valid & in_ready;

    // Decode the opcode and resolve direction, next PC and mispredict.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        is_branch = 1'b0;
        case (in_opcode)
            OP_BLT, OP_BGT, OP_BLTU, OP_BGTU, OP_BEQ, OP_BNE: is_branch = 1'b1;
            default: is_branch = 1'b0;
        endcase
        taken      = is_branch & in_cmp_result[0];
        next_pc    = taken ? (in_pc + in_imm) : (in_pc + 32'd4);
        mispredict = taken ^ in_pred_taken;
    end

    // Next state of the output register, the redirect pulse and the BHT.
    always_comb begin
        out_valid_d      = out_valid_q;
        out_taken_d      = out_taken_q;
        out_next_pc_d    = out_next_pc_q;
        out_mispredict_d = out_mispredict_q;
        redirect_valid_d = 1'b0;
        bht_d            = bht_q;
        train_cnt        = bht_q[train_idx];

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d      = 1'b1;
            out_taken_d      = taken;
            out_next_pc_d    = next_pc;
            out_mispredict_d = mispredict;
            redirect_valid_d = mispredict;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (capture && is_branch) begin
            if (taken) begin
                bht_d[train_idx] = (train_cnt == 2'b11) ? 2'b11 : train_cnt + 2'b01;
            end else begin
                bht_d[train_idx] = (train_cnt == 2'b00) ? 2'b00 : train_cnt - 2'b01;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            out_taken_q      <= 1'b0;
            out_next_pc_q    <= '0;
            out_mispredict_q <= 1'b0;
            redirect_valid_q <= 1'b0;
            // NOTE: the BHT is a small flop array rather than a RAM, so it can
            // take a real reset value; predictors start weakly not-taken.
            bht_q            <= '{default: CNT_INIT};
        end else begin
            out_valid_q      <= out_valid_d;
            out_taken_q      <= out_taken_d;
            out_next_pc_q    <= out_next_pc_d;
            out_mispredict_q <= out_mispredict_d;
            redirect_valid_q <= redirect_valid_d;
            bht_q            <= bht_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_taken      = out_taken_q;
    assign out_next_pc    = out_next_pc_q;
    assign out_mispredict = out_mispredict_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = out_next_pc_q;

    // Read-before-write: the query sees the pre-edge counter.
    assign pred_taken = bht_q[query_idx][1];

endmodule
